// File: rtl/tristate_bus_sched.sv
// Purpose: round-robin owner scheduler for one shared tri-state bus built from bufif0 drivers (active-low enables).
// Latency: oe_n falls one edge after a request is seen in IDLE; grant follows cfg_on_dly+1 edges later; all outputs registered.
// Backpressure: none; requesters hold req (level) until they are granted, and the owner releases the bus with done or by dropping req.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   req[N_REQ]               per-requester level request
//   done[N_REQ]              per-requester release pulse, honoured only from the current owner while it owns the bus
//   cfg_on_dly, cfg_off_dly  settle cycles before grant / dead cycles after release (latched when the window starts)
//   oe_n[N_REQ]              active-low driver enables, at most one low at a time
//   grant[N_REQ]             one-hot grant, the owner may drive data
//   owner_id                 index of the current or most recent owner
//   busy                     high whenever the scheduler is not idle
//   timeout                  one-cycle pulse when an owner is forced off after MAX_HOLD cycles
module tristate_bus_sched #(
  parameter int N_REQ    = 4,
  parameter int CNT_W    = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           done,
  input  logic [CNT_W-1:0]           cfg_on_dly,
  input  logic [CNT_W-1:0]           cfg_off_dly,
  output logic [N_REQ-1:0]           oe_n,
  output logic [N_REQ-1:0]           grant,
  output logic [$clog2(N_REQ)-1:0]   owner_id,
  output logic                       busy,
  output logic                       timeout
);

  localparam int ID_W   = $clog2(N_REQ);
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  // Hold counter value on the last permitted cycle of ownership.
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;
  localparam bit                HOLD_EN   = (MAX_HOLD != 0);
  // Pointer resets to the last index so that index 0 wins the first arbitration.
  localparam logic [ID_W-1:0]   PTR_RST   = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    OWN     = 2'd2,
    TURNOFF = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     ptr, ptr_nxt;
  logic [ID_W-1:0]     owner_nxt;
  logic [N_REQ-1:0]    oe_n_nxt;
  logic [N_REQ-1:0]    grant_nxt;
  logic                busy_nxt;
  logic                timeout_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [HOLD_W-1:0]   hold, hold_nxt;

  logic [ID_W-1:0]     rr_pick;
  logic                rr_found;
  logic                own_req;
  logic                own_done;
  logic                hold_hit;
  logic                release_now;

  // Round-robin search: first set req starting at ptr+1, wrapping, so the
  // previous owner (held in ptr) is examined last.
  always_comb begin
    logic [ID_W-1:0] cand;
    rr_pick  = '0;
    rr_found = 1'b0;
    cand     = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = ID_W'((int'(ptr) + i) % N_REQ);
      if (!rr_found && req[cand]) begin
        rr_found = 1'b1;
        rr_pick  = cand;
      end
    end
  end

  assign own_req     = req[owner_id];
  assign own_done    = done[owner_id];
  assign hold_hit    = HOLD_EN && (hold == HOLD_LAST);
  assign release_now = own_done || !own_req || hold_hit;

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    owner_nxt   = owner_id;
    oe_n_nxt    = oe_n;
    grant_nxt   = grant;
    cnt_nxt     = cnt;
    hold_nxt    = hold;
    timeout_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (rr_found) begin
          ptr_nxt           = rr_pick;
          owner_nxt         = rr_pick;
          oe_n_nxt          = '1;
          oe_n_nxt[rr_pick] = 1'b0;
          cnt_nxt           = cfg_on_dly;
          state_nxt         = SETUP;
        end
      end

      SETUP: begin
        if (!own_req) begin
          // Requester gave up while its driver was still settling: turn it
          // off and honour the dead window before anyone else may drive.
          oe_n_nxt  = '1;
          cnt_nxt   = cfg_off_dly;
          state_nxt = TURNOFF;
        end else if (cnt == '0) begin
          grant_nxt           = '0;
          grant_nxt[owner_id] = 1'b1;
          hold_nxt            = '0;
          state_nxt           = OWN;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      OWN: begin
        if (release_now) begin
          grant_nxt   = '0;
          oe_n_nxt    = '1;
          cnt_nxt     = cfg_off_dly;
          state_nxt   = TURNOFF;
          // Forced only when the limit alone caused the release; a coincident
          // done or req drop counts as a normal release.
          timeout_nxt = own_req && !own_done;
        end else begin
          hold_nxt = hold + 1'b1;
        end
      end

      TURNOFF: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
        oe_n_nxt  = '1;
        grant_nxt = '0;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= PTR_RST;
      owner_id <= '0;
      oe_n     <= '1;
      grant    <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      cnt      <= '0;
      hold     <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      owner_id <= owner_nxt;
      oe_n     <= oe_n_nxt;
      grant    <= grant_nxt;
      busy     <= busy_nxt;
      timeout  <= timeout_nxt;
      cnt      <= cnt_nxt;
      hold     <= hold_nxt;
    end
  end

  // Electrical safety properties of the enable outputs.
  a_one_driver:   assert property (@(posedge clk) disable iff (rst) $onehot0(~oe_n));
  a_grant_driven: assert property (@(posedge clk) disable iff (rst) (grant & oe_n) == '0);
  a_grant_in_own: assert property (@(posedge clk) disable iff (rst) (state == OWN) || (grant == '0));
  a_off_quiet:    assert property (@(posedge clk) disable iff (rst)
                                   (state == SETUP) || (state == OWN) || (oe_n == '1));
  a_busy_state:   assert property (@(posedge clk) disable iff (rst) busy == (state != IDLE));

endmodule
